// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS core: shadows EX/MEM/WB register
// tags (Tuse/Tnew model) and produces forward selects, the ID stall and the mult/div interlock.
module hazard_forward_ctrl #(
   parameter int REG_AW  = 5,
   parameter int NSRC    = 2,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   id_valid,
   input  logic [NSRC*REG_AW-1:0] id_src,
   input  logic [NSRC*2-1:0]      id_tuse,
   input  logic [REG_AW-1:0]      id_dst,
   input  logic                   id_we,
   input  logic [1:0]             id_tnew,
   input  logic                   id_md_start,
   input  logic                   id_md_div,
   input  logic                   id_md_use,
   input  logic                   flush,
   output logic                   stall,
   output logic [NSRC*2-1:0]      fwd_id,
   output logic [NSRC*2-1:0]      fwd_ex,
   output logic                   fwd_mem,
   output logic                   md_busy
);

   localparam int RT     = (NSRC > 1) ? 1 : 0;
   localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int CNT_W  = $clog2(MAXLAT + 1);

   function automatic logic [1:0] f_tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   function automatic logic f_match(input logic v, input logic we,
                                    input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] s);
      return v && we && (dst == s) && (s != '0);
   endfunction

   // p0 = EX entry, p1 = MEM entry, p2 = WB entry
   logic                   r_vld_p0, r_vld_p1, r_vld_p2;
   logic [REG_AW-1:0]      r_dst_p0, r_dst_p1, r_dst_p2;
   logic                   r_we_p0, r_we_p1, r_we_p2;
   logic [1:0]             r_tnew_p0, r_tnew_p1;
   logic [NSRC*REG_AW-1:0] r_src_p0;
   logic [REG_AW-1:0]      r_rt_p1;
   logic                   r_mds_p0, r_mdd_p0;
   logic [CNT_W-1:0]       r_md_cnt;

   logic w_ex_load;
   logic w_src_stall;

   assign w_ex_load = id_valid && !stall && !flush;
   assign md_busy   = (r_md_cnt != '0) || (r_vld_p0 && r_mds_p0);
   assign stall     = id_valid && (w_src_stall || (id_md_use && md_busy));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
         r_md_cnt <= '0;
      end else begin
         r_vld_p0 <= w_ex_load;
         r_vld_p1 <= r_vld_p0;
         r_vld_p2 <= r_vld_p1;
         // a running count is never restarted by a later start
         if (r_md_cnt != '0)
            r_md_cnt <= r_md_cnt - CNT_W'(1);
         else if (r_vld_p0 && r_mds_p0)
            r_md_cnt <= r_mdd_p0 ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end
   end

   // ID -> EX -> MEM -> WB tag shift; qualified only by the valid bits
   always_ff @(posedge clk) begin
      r_dst_p0  <= id_dst;
      r_we_p0   <= id_we;
      r_tnew_p0 <= id_tnew;
      r_src_p0  <= id_src;
      r_mds_p0  <= id_md_start;
      r_mdd_p0  <= id_md_div;
      r_dst_p1  <= r_dst_p0;
      r_we_p1   <= r_we_p0;
      r_tnew_p1 <= f_tnew_dec(r_tnew_p0);
      r_rt_p1   <= r_src_p0[RT*REG_AW +: REG_AW];
      r_dst_p2  <= r_dst_p1;
      r_we_p2   <= r_we_p1;
   end

   // youngest matching writer decides; older writers to the same register are shadowed
   always_comb begin
      w_src_stall = 1'b0;
      fwd_id      = '0;
      fwd_ex      = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (id_valid && (id_tuse[i*2 +: 2] != 2'd3)) begin
            if (f_match(r_vld_p0, r_we_p0, r_dst_p0, id_src[i*REG_AW +: REG_AW])) begin
               if (r_tnew_p0 > id_tuse[i*2 +: 2]) w_src_stall = 1'b1;
               if (r_tnew_p0 == 2'd0) fwd_id[i*2 +: 2] = 2'b11;
            end else if (f_match(r_vld_p1, r_we_p1, r_dst_p1, id_src[i*REG_AW +: REG_AW])) begin
               if (r_tnew_p1 > id_tuse[i*2 +: 2]) w_src_stall = 1'b1;
               if (r_tnew_p1 == 2'd0) fwd_id[i*2 +: 2] = 2'b10;
            end else if (f_match(r_vld_p2, r_we_p2, r_dst_p2, id_src[i*REG_AW +: REG_AW])) begin
               fwd_id[i*2 +: 2] = 2'b01;
            end
         end
         if (r_vld_p0) begin
            if (f_match(r_vld_p1, r_we_p1, r_dst_p1, r_src_p0[i*REG_AW +: REG_AW]))
               fwd_ex[i*2 +: 2] = 2'b10;
            else if (f_match(r_vld_p2, r_we_p2, r_dst_p2, r_src_p0[i*REG_AW +: REG_AW]))
               fwd_ex[i*2 +: 2] = 2'b01;
         end
      end
      fwd_mem = r_vld_p1 && f_match(r_vld_p2, r_we_p2, r_dst_p2, r_rt_p1);
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed pipeline scenarios followed by
// random instruction streams, compared against an age-based reference model.
module tb_hazard_forward_ctrl;
   localparam int REG_AW  = 5;
   localparam int NSRC    = 2;
   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic                   clk;
   logic                   reset_n;
   logic                   id_valid;
   logic [NSRC*REG_AW-1:0] id_src;
   logic [NSRC*2-1:0]      id_tuse;
   logic [REG_AW-1:0]      id_dst;
   logic                   id_we;
   logic [1:0]             id_tnew;
   logic                   id_md_start;
   logic                   id_md_div;
   logic                   id_md_use;
   logic                   flush;
   logic                   stall;
   logic [NSRC*2-1:0]      fwd_id;
   logic [NSRC*2-1:0]      fwd_ex;
   logic                   fwd_mem;
   logic                   md_busy;

   hazard_forward_ctrl #(.REG_AW(REG_AW), .NSRC(NSRC), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_src(id_src), .id_tuse(id_tuse),
      .id_dst(id_dst), .id_we(id_we), .id_tnew(id_tnew), .id_md_start(id_md_start),
      .id_md_div(id_md_div), .id_md_use(id_md_use), .flush(flush), .stall(stall),
      .fwd_id(fwd_id), .fwd_ex(fwd_ex), .fwd_mem(fwd_mem), .md_busy(md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: instructions indexed by age past ID (0=EX, 1=MEM, 2=WB)
   typedef struct packed {
      bit v; int dst; bit we; int tnew; int src0; int src1; bit mds; bit mdd;
   } ent_t;

   ent_t       pipe [3];
   int         cyc;
   int         md_end;   // first cycle in which the HI/LO countdown is back to zero
   int         total;
   int         bad;
   logic       e_stall, e_fmem, e_busy;
   logic [3:0] e_fid, e_fex;

   function automatic int youngest(input int s, input int from);
      for (int a = from; a < 3; a++)
         if (pipe[a].v && pipe[a].we && pipe[a].dst == s && s != 0) return a;
      return -1;
   endfunction

   task automatic compute_exp();
      int srcs [2];
      int tus [2];
      int a;
      int rem;
      int s;
      logic st;
      srcs[0] = int'(id_src[4:0]);
      srcs[1] = int'(id_src[9:5]);
      tus[0]  = int'(id_tuse[1:0]);
      tus[1]  = int'(id_tuse[3:2]);
      e_busy  = (md_end > cyc) || (pipe[0].v && pipe[0].mds);
      e_fid   = '0;
      e_fex   = '0;
      st      = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (id_valid && tus[i] != 3) begin
            a = youngest(srcs[i], 0);
            if (a == 0 || a == 1) begin
               rem = pipe[a].tnew - a;
               if (rem < 0) rem = 0;
               if (rem > tus[i]) st = 1'b1;
               if (rem == 0) e_fid[i*2 +: 2] = (a == 0) ? 2'b11 : 2'b10;
            end else if (a == 2) begin
               e_fid[i*2 +: 2] = 2'b01;
            end
         end
         if (pipe[0].v) begin
            s = (i == 0) ? pipe[0].src0 : pipe[0].src1;
            a = youngest(s, 1);
            if (a == 1) e_fex[i*2 +: 2] = 2'b10;
            else if (a == 2) e_fex[i*2 +: 2] = 2'b01;
         end
      end
      e_fmem  = pipe[1].v && (youngest(pipe[1].src1, 2) == 2);
      e_stall = id_valid && (st || (id_md_use && e_busy));
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sample(input string tag);
      @(negedge clk);
      compute_exp();
      chk({tag, ".stall"},   8'(stall),   8'(e_stall));
      chk({tag, ".fwd_id"},  8'(fwd_id),  8'(e_fid));
      chk({tag, ".fwd_ex"},  8'(fwd_ex),  8'(e_fex));
      chk({tag, ".fwd_mem"}, 8'(fwd_mem), 8'(e_fmem));
      chk({tag, ".md_busy"}, 8'(md_busy), 8'(e_busy));
   endtask

   task automatic advance();
      ent_t n;
      compute_exp();
      @(posedge clk);
      if (!reset_n) begin
         for (int a = 0; a < 3; a++) pipe[a].v = 1'b0;
         md_end = cyc + 1;
      end else begin
         if (md_end <= cyc && pipe[0].v && pipe[0].mds)
            md_end = cyc + 1 + (pipe[0].mdd ? DIV_LAT : MUL_LAT);
         n.v    = id_valid && !e_stall && !flush;
         n.dst  = int'(id_dst);
         n.we   = id_we;
         n.tnew = int'(id_tnew);
         n.src0 = int'(id_src[4:0]);
         n.src1 = int'(id_src[9:5]);
         n.mds  = id_md_start;
         n.mdd  = id_md_div;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = n;
      end
      cyc++;
      #1;
   endtask

   task automatic step(input string tag);
      sample(tag);
      advance();
   endtask

   task automatic drive(input bit v, input int s0, input int t0, input int s1, input int t1,
                        input int dst, input bit we, input int tnew,
                        input bit mds, input bit mdd, input bit mdu);
      id_valid    = v;
      id_src      = {REG_AW'(s1), REG_AW'(s0)};
      id_tuse     = {2'(t1), 2'(t0)};
      id_dst      = REG_AW'(dst);
      id_we       = we;
      id_tnew     = 2'(tnew);
      id_md_start = mds;
      id_md_div   = mdd;
      id_md_use   = mdu;
   endtask

   task automatic idle();
      drive(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int n;
      total   = 0;
      bad     = 0;
      cyc     = 0;
      md_end  = 0;
      for (int a = 0; a < 3; a++) pipe[a] = '0;
      reset_n = 1'b0;
      flush   = 1'b0;
      idle();
      #1;
      advance();
      advance();
      sample("rst_hold");
      advance();
      reset_n = 1'b1;
      sample("rst_rel");
      chk("rst_stall",   8'(stall),   8'd0);
      chk("rst_fwd_id",  8'(fwd_id),  8'd0);
      chk("rst_fwd_ex",  8'(fwd_ex),  8'd0);
      chk("rst_fwd_mem", 8'(fwd_mem), 8'd0);
      chk("rst_md_busy", 8'(md_busy), 8'd0);
      advance();

      // addu r1,r2,r3 ; addu r3,r1,r2
      drive(1, 2, 1, 3, 1, 1, 1, 1, 0, 0, 0); step("addu1");
      drive(1, 1, 1, 2, 1, 3, 1, 1, 0, 0, 0); sample("addu2");
      chk("addu_nostall", 8'(stall), 8'd0); advance();
      idle(); sample("addu3");
      chk("addu_fwd_ex", 8'(fwd_ex[1:0]), 8'd2); advance();
      sample("addu4");
      chk("addu_fwd_ex_after", 8'(fwd_ex[1:0]), 8'd0); advance();
      step("gap"); step("gap");

      // lw r2 ; beq r2,r0
      drive(1, 0, 3, 0, 3, 2, 1, 2, 0, 0, 0); step("lw1");
      drive(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      sample("beq_a"); chk("beq_stall_a", 8'(stall), 8'd1); advance();
      sample("beq_b"); chk("beq_stall_b", 8'(stall), 8'd1); advance();
      sample("beq_c"); chk("beq_stall_c", 8'(stall), 8'd0);
      chk("beq_fwd_id", 8'(fwd_id[1:0]), 8'd1); advance();
      idle(); step("gap"); step("gap"); step("gap");

      // jal ; jr r31
      drive(1, 0, 3, 0, 3, 31, 1, 0, 0, 0, 0); step("jal");
      drive(1, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0); sample("jr");
      chk("jr_stall", 8'(stall), 8'd0);
      chk("jr_fwd_id", 8'(fwd_id[1:0]), 8'd3); advance();
      idle(); step("gap"); step("gap"); step("gap");

      // lw r2 ; sw r2,0(r4)
      drive(1, 0, 3, 0, 3, 2, 1, 2, 0, 0, 0); step("lw2");
      drive(1, 4, 1, 2, 2, 0, 0, 0, 0, 0, 0); sample("sw_id");
      chk("sw_stall", 8'(stall), 8'd0); advance();
      idle(); sample("sw_ex");
      chk("sw_fwd_ex_rt", 8'(fwd_ex[3:2]), 8'd2); advance();
      sample("sw_mem");
      chk("sw_fwd_mem", 8'(fwd_mem), 8'd1); advance();
      step("gap"); step("gap");

      // write to r0, then consume r0
      drive(1, 0, 3, 0, 3, 0, 1, 2, 0, 0, 0); step("r0w");
      drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); sample("r0r");
      chk("r0_stall", 8'(stall), 8'd0);
      chk("r0_fwd_id", 8'(fwd_id), 8'd0); advance();
      idle(); sample("r0ex");
      chk("r0_fwd_ex", 8'(fwd_ex), 8'd0); advance();
      step("gap"); step("gap");

      // mult ; mflo  -> six stall cycles
      drive(1, 0, 3, 0, 3, 0, 0, 0, 1, 0, 1); step("mult");
      drive(1, 0, 3, 0, 3, 5, 1, 1, 0, 0, 1);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         sample("mflo");
         if (stall !== 1'b1) break;
         n++;
         advance();
      end
      chk("mflo_stall_cycles", 8'(n), 8'd6);
      advance();
      idle(); step("gap"); step("gap");

      // mult ; mflo with reset in the third busy cycle
      drive(1, 0, 3, 0, 3, 0, 0, 0, 1, 0, 1); step("mult2");
      drive(1, 0, 3, 0, 3, 5, 1, 1, 0, 0, 1);
      step("mflo2_1"); step("mflo2_2");
      reset_n = 1'b0; step("mflo2_rst");
      reset_n = 1'b1; sample("mflo2_post");
      chk("rst_mid_md_busy", 8'(md_busy), 8'd0);
      chk("rst_mid_stall", 8'(stall), 8'd0); advance();
      idle(); step("gap");

      // random instruction streams
      for (int k = 0; k < 600; k++) begin
         drive($urandom_range(7) != 0,
               $urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
               $urandom_range(3), $urandom_range(1), $urandom_range(2),
               $urandom_range(11) == 0, $urandom_range(1), $urandom_range(3) == 0);
         if (id_md_start) id_md_use = 1'b1;
         flush   = ($urandom_range(9) == 0);
         reset_n = ($urandom_range(79) != 0);
         step($sformatf("rnd%0d", k));
      end
      reset_n = 1'b1;
      flush   = 1'b0;
      idle();
      step("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
